checker_controller: RTL

Sequencing FSM for the convolution checker datapath. It accepts a job start and gates MAC issue on the datapath's `can_mult`/`can_count` flags. It drives `load` to advance the IF/filter pointer registers, drains the multiplier pipeline at each window end (`par_done`), and writes the partial sum when the scratchpad allows it (`scratch_write_en`). It finishes the job on `Done`. It sits between the top-level job interface and the checker datapath and MAC unit.

---
 rtl/checker_controller_if.sv | 29 ++
 rtl/checker_controller.sv | 114 +++++++++++
 2 files changed

// File: rtl/checker_controller_if.sv
// Job/datapath handshake bundle for the convolution checker controller.
// The controller uses the slave view; the job source and datapath drive the master view.
interface checker_controller_if #(
  parameter int STALL_CNT_SIZE = 8
);
  logic                      start;
  logic                      can_mult;
  logic                      can_count;
  logic                      par_done;
  logic                      Done;
  logic                      scratch_write_en;
  logic                      load;
  logic                      mult_en;
  logic                      psum_clear;
  logic                      psum_write;
  logic                      busy;
  logic                      done_out;
  logic [STALL_CNT_SIZE-1:0] stall_count;

  modport master (
    output start, can_mult, can_count, par_done, Done, scratch_write_en,
    input  load, mult_en, psum_clear, psum_write, busy, done_out, stall_count
  );

  modport slave (
    input  start, can_mult, can_count, par_done, Done, scratch_write_en,
    output load, mult_en, psum_clear, psum_write, busy, done_out, stall_count
  );
endinterface

// File: rtl/checker_controller.sv
// Sequencing FSM for the convolution checker datapath: gates MAC issue, drains the
// multiplier pipeline at each window end and writes the partial sum to the scratchpad.
//
// state    | meaning
// IDLE     | waiting for a job start
// INIT     | clear the accumulator for a new window
// WAIT     | operands/pointers not ready; counts stalls
// MAC      | issue one MAC and advance the pointers
// DRAIN    | let the multiplier pipeline settle (PSUM_LATENCY cycles)
// WRITE    | write the psum when the scratchpad allows; counts stalls
// FINISH   | one-cycle job-complete pulse
module checker_controller #(
  parameter int PSUM_LATENCY   = 2,
  parameter int STALL_CNT_SIZE = 8
) (
  input logic                 clk,
  input logic                 rst,
  checker_controller_if.slave ctl
);

  if (PSUM_LATENCY < 1 || PSUM_LATENCY > 15) begin : g_bad_latency
    $error("PSUM_LATENCY must be in 1..15");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_WAIT, S_MAC, S_DRAIN, S_WRITE, S_FINISH
  } state_t;

  localparam logic [3:0] DRAIN_LAST = 4'(PSUM_LATENCY - 1);

  state_t                    state_q, state_d;
  logic [STALL_CNT_SIZE-1:0] stall_q, stall_d;
  logic [3:0]                drain_q, drain_d;
  logic                      load_q, mult_en_q, psum_clear_q, busy_q, done_q;
  logic                      stall_inc, stall_clr, go;

  assign go = ctl.can_mult && ctl.can_count;

  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    stall_inc = 1'b0;
    stall_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ctl.start) begin
          state_d   = S_INIT;
          stall_clr = 1'b1;
        end
      end
      S_INIT: state_d = S_WAIT;
      S_WAIT: begin
        if (ctl.Done)  state_d = S_FINISH;
        else if (go)   state_d = S_MAC;
        else           stall_inc = 1'b1;
      end
      S_MAC: begin
        // A window end is always drained and written, even if Done is already up.
        if (ctl.par_done) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else if (!go) begin
          state_d = S_WAIT;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = S_WRITE;
        else                       drain_d = drain_q + 4'd1;
      end
      S_WRITE: begin
        if (ctl.scratch_write_en) state_d = ctl.Done ? S_FINISH : S_INIT;
        else                      stall_inc = 1'b1;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    stall_d = stall_q;
    if (stall_clr)                     stall_d = '0;
    else if (stall_inc && stall_q != '1) stall_d = stall_q + 1'b1;
  end

  // Moore outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      stall_q      <= '0;
      drain_q      <= '0;
      load_q       <= 1'b0;
      mult_en_q    <= 1'b0;
      psum_clear_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      stall_q      <= stall_d;
      drain_q      <= drain_d;
      load_q       <= (state_d == S_MAC);
      mult_en_q    <= (state_d == S_MAC);
      psum_clear_q <= (state_d == S_INIT);
      busy_q       <= (state_d != S_IDLE);
      done_q       <= (state_d == S_FINISH);
    end
  end

  assign ctl.load        = load_q;
  assign ctl.mult_en     = mult_en_q;
  assign ctl.psum_clear  = psum_clear_q;
  assign ctl.psum_write  = (state_q == S_WRITE) && ctl.scratch_write_en;
  assign ctl.busy        = busy_q;
  assign ctl.done_out    = done_q;
  assign ctl.stall_count = stall_q;

endmodule
